tenv_wbinit: RTL
================

Name: tenv_wbinit

Overview:
- Test-environment Wishbone pipelined bus initiator. It is the requesting end of the same cyc/stb/stall/ack protocol that the tenv memory responders implement.
- Lets a test drive a responder (tenv_dmem, tenv_pmain, tenv_pexc) directly, without the CPU core, by turning a simple command stream into pipelined bus cycles.
- Tracks outstanding requests and returns responses in order.
- Detects protocol errors: spurious ack and ack timeout.

Parameters:
MAX_OUTST, 4, maximum requests issued but not yet acked; power of two, 1..16
TIMEOUT, 64, cycles allowed with pend!=0 and no ack before error; >=2

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted this cycle when cmd_valid=1
cmd_we  in  1  1=write, 0=read
cmd_adr  in  32  byte address; bits [1:0] ignored
cmd_sel  in  4  byte selects
cmd_dat  in  32  write data
rsp_valid  out  1  one-cycle response pulse
rsp_we  out  1  cmd_we of the completed request
rsp_dat  out  32  dat_i captured on ack (reads); don't-care for writes
err_o  out  1  sticky protocol error
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  write enable
sel_o  out  4  byte selects
adr_o  out  30  word address, cmd_adr[31:2]
dat_o  out  32  write data
dat_i  in  32  read data
ack_i  in  1  acknowledge
stall_i  in  1  responder stall

Behaviour:
- Reset (rst_i=1 at clock edge), values on the next cycle:
  - cyc_o=stb_o=we_o=0, sel_o=0, adr_o=0, dat_o=0.
  - rsp_valid=0, rsp_we=0, rsp_dat=0, err_o=0.
  - pend=0, tag FIFO empty, timeout counter=0, state IDLE.
  - Reset mid-transaction abandons all outstanding requests; no responses are produced for them.
- Issue: a request is issued on a cycle with stb_o=1 and stall_i=0.
- pend: count of issued, unacked requests, width clog2(MAX_OUTST)+1.
  - +1 on issue, -1 on accepted ack; both in the same cycle leave it unchanged.
- Command acceptance:
  - cmd_ready = !err_o & (!stb_o | !stall_i) & (pend + stb_o < MAX_OUTST). Combinational from registers and stall_i.
  - On accept, the next cycle has stb_o=1 and we_o/sel_o/adr_o/dat_o loaded from cmd_*. Latency from cmd accept to stb_o is 1 cycle.
  - Without a new accept, stb_o drops after issue.
  - While stall_i=1, stb_o and all request outputs hold stable.
- Back-to-back: a stream with cmd_valid=1 and stall_i=0 yields stb_o on consecutive cycles until pend reaches the limit.
- cyc_o = stb_o | (pend!=0), registered consistently. It must not drop while any request is unacked.
- Tag FIFO:
  - Depth MAX_OUTST, holds we per issued request; written on issue, read on accepted ack.
  - Never overflows because of the cmd_ready rule.
- Response:
  - An accepted ack is ack_i=1 with pend!=0.
  - Next cycle: rsp_valid=1, rsp_dat=dat_i, rsp_we=FIFO head.
  - Responses are returned in issue order; rsp_valid is never asserted for 2 cycles per ack.
- Spurious ack: ack_i=1 with pend==0 sets err_o, produces no response, and leaves pend unchanged.
- Timeout counter:
  - Cleared on accepted ack or when pend==0.
  - Otherwise increments each cycle.
  - Reaching TIMEOUT sets err_o.
- States:
  - IDLE: cyc_o=0. Goes to BUSY on command accept.
  - BUSY: cyc_o=1. Goes to IDLE when pend becomes 0 and no stb_o is pending. Goes to ERROR on err_o set.
  - ERROR: cyc_o=stb_o=0, pend=0, FIFO flushed, cmd_ready=0, further ack_i ignored. Leaves only via rst_i.
- Simultaneous events: issue plus ack in one cycle both count. The timeout threshold hit in the same cycle as an ack does not set err_o (the ack wins).

Test Plan:
- Single read: cmd read adr=0x0000_0010, responder acks 2 cycles after issue with dat_i=0xDEADBEEF -> adr_o=0x4 with stb_o for 1 cycle; rsp_valid 1 cycle later with rsp_dat=0xDEADBEEF, rsp_we=0; cyc_o low after the response.
- Pipelined writes: 4 writes, stall_i=0, MAX_OUTST=4, ack delayed 5 cycles -> 4 consecutive stb_o; cmd_ready=0 when pend=4; 4 rsp_valid pulses with rsp_we=1, in order.
- Stall hold: stall_i=1 for 3 cycles during write adr=0x20 dat=0x12345678 sel=4'b0011 -> outputs stable for those 3 cycles; issued on the 4th cycle; pend=1.
- Mixed order: W,R,W,R with acks and read data 0x1, 0x2 -> rsp_we sequence 1,0,1,0; read rsp_dat 0x1 then 0x2.
- Spurious ack: ack_i=1 while idle -> err_o=1 next cycle, no rsp_valid, cmd_ready=0 thereafter.
- Timeout and reset: read issued, no ack for 64 cycles -> err_o=1, cyc_o=0. Then rst_i=1 for 1 cycle -> all outputs 0 and cmd_ready=1 again.

Source files
------------

// File: rtl/tenv_wbinit.sv
// Wishbone pipelined bus initiator for the test environment: turns a command
// stream into cyc/stb/stall/ack cycles, returns responses in order, flags protocol errors.
module tenv_wbinit #(
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic [31:0] rsp_dat,
  output logic        err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [29:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        stall_i
);

  localparam int PW = $clog2(MAX_OUTST) + 1;
  localparam int AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   MAX_W = (PW+1)'(MAX_OUTST);
  localparam logic [TW-1:0] TMO_W = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, ERROR} state_e;

  state_e        state_q, state_d;
  logic          stb_q, stb_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [29:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [PW-1:0] pend_q, pend_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          fifo_q [MAX_OUTST];
  logic          fifo_d [MAX_OUTST];
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_we_q, rsp_we_d;
  logic [31:0]   rsp_dat_q, rsp_dat_d;
  logic          err_q, err_d;

  logic          issue, ack_acc, ack_spur, accept, tmo_hit;
  logic [PW:0]   occ;
  logic          unused_adr;

  assign unused_adr = ^cmd_adr[1:0];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy counts a request still sitting on stb so the FIFO can never overflow.
  assign occ       = {1'b0, pend_q} + (PW+1)'(stb_q);
  assign cmd_ready = !err_q & (!stb_q | !stall_i) & (occ < MAX_W);
  assign accept    = cmd_valid & cmd_ready;
  assign issue     = stb_q & !stall_i;
  assign ack_acc   = ack_i & (pend_q != '0) & (state_q != ERROR);
  assign ack_spur  = ack_i & (pend_q == '0) & (state_q != ERROR);

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_d      = fifo_q;
    rsp_we_d    = rsp_we_q;
    rsp_dat_d   = rsp_dat_q;
    err_d       = err_q;
    rsp_valid_d = ack_acc;
    tmo_d       = '0;
    tmo_hit     = 1'b0;

    if (ack_acc) begin
      rsp_we_d  = fifo_q[rd_ptr_q];
      rsp_dat_d = dat_i;
      rd_ptr_d  = ptr_inc(rd_ptr_q);
    end

    if (accept) begin
      stb_d = 1'b1;
      we_d  = cmd_we;
      sel_d = cmd_sel;
      adr_d = cmd_adr[31:2];
      dat_d = cmd_dat;
    end else if (issue) begin
      stb_d = 1'b0;
    end

    if (issue) begin
      fifo_d[wr_ptr_q] = we_q;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    pend_d = pend_q + PW'(issue) - PW'(ack_acc);

    // An ack in the threshold cycle clears the counter and beats the timeout.
    if (!ack_acc && pend_q != '0) begin
      tmo_d   = tmo_q + 1'b1;
      tmo_hit = (tmo_d == TMO_W);
    end

    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (pend_d == '0 && !stb_d) state_d = IDLE;
      default: state_d = ERROR;
    endcase

    if (ack_spur || tmo_hit) begin
      err_d    = 1'b1;
      state_d  = ERROR;
      stb_d    = 1'b0;
      pend_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      tmo_d    = '0;
    end

    cyc_d = (state_d != ERROR) & (stb_d | (pend_d != '0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      stb_q       <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      pend_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_dat_q   <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= 1'b0;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      pend_q      <= pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_dat_q   <= rsp_dat_d;
      err_q       <= err_d;
      for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  assign cyc_o     = cyc_q;
  assign stb_o     = stb_q;
  assign we_o      = we_q;
  assign sel_o     = sel_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_dat   = rsp_dat_q;
  assign err_o     = err_q;

endmodule
